// File: rtl/viterbi_pkg.sv
// Shared definitions for the 4-state (K=3, rate 1/2) hard-decision Viterbi datapath:
// trellis predecessor table, default widths and the minimum-PM selector.
package viterbi_pkg;

  localparam int NUM_STATES   = 4;
  localparam int PM_W_DEF     = 6;
  localparam int INIT_PEN_DEF = 16;
  localparam int PM_MAX_W     = 16;

  typedef logic [PM_MAX_W-1:0] pm_t;
  typedef logic [1:0]          state_t;

  // State s is entered from {s[0],0} (even predecessor) or {s[0],1} (odd predecessor).
  localparam logic [NUM_STATES-1:0][1:0] P0_TAB = {2'd2, 2'd0, 2'd2, 2'd0};
  localparam logic [NUM_STATES-1:0][1:0] P1_TAB = {2'd3, 2'd1, 2'd3, 2'd1};

  // Index of the smallest metric; strict compare keeps the lowest index on ties.
  function automatic state_t pm_argmin(input pm_t [NUM_STATES-1:0] pm);
    state_t idx;
    pm_t    best;
    idx  = '0;
    best = pm[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (pm[s] < best) begin
        best = pm[s];
        idx  = state_t'(s);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/acs_node.sv
// One add-compare-select cell: extends both candidates by a bit so the sum never wraps,
// and picks the even predecessor unless the odd one is strictly better.
module acs_node
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W:0]   pm_o,
  output logic            dec_o
);

  logic [PM_W:0] cand0, cand1;

  assign cand0 = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
  assign cand1 = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
  assign dec_o = (cand1 < cand0);
  assign pm_o  = dec_o ? cand1 : cand0;

endmodule

// File: rtl/acs_unit.sv
// Add-compare-select stage: four ACS cells feeding registered path metrics with
// common-offset normalization, best-state tracking and a saturating symbol counter.
module acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W     = PM_W_DEF,
  parameter int INIT_PEN = INIT_PEN_DEF,
  parameter int CNT_W    = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             bm_valid_i,
  input  logic [1:0]       bm_s0_s0_i,
  input  logic [1:0]       bm_s0_s2_i,
  input  logic [1:0]       bm_s1_s0_i,
  input  logic [1:0]       bm_s1_s2_i,
  input  logic [1:0]       bm_s2_s1_i,
  input  logic [1:0]       bm_s2_s3_i,
  input  logic [1:0]       bm_s3_s1_i,
  input  logic [1:0]       bm_s3_s3_i,
  output logic             dec_valid_o,
  output logic [3:0]       dec_o,
  output logic [PM_W-1:0]  pm_s0_o,
  output logic [PM_W-1:0]  pm_s1_o,
  output logic [PM_W-1:0]  pm_s2_o,
  output logic [PM_W-1:0]  pm_s3_o,
  output logic [1:0]       best_state_o,
  output logic             norm_o,
  output logic [CNT_W-1:0] sym_cnt_o
);

  localparam logic [PM_W-1:0] PEN  = PM_W'(INIT_PEN);
  localparam logic [PM_W:0]   HALF = (PM_W+1)'(1) << (PM_W-1);

  logic [NUM_STATES-1:0][PM_W-1:0] pm_q, pm_d;
  logic [NUM_STATES-1:0][PM_W:0]   acs_pm, norm_pm;
  logic [NUM_STATES-1:0][1:0]      bm0, bm1;
  logic [NUM_STATES-1:0]           acs_dec, dec_q;
  pm_t  [NUM_STATES-1:0]           pm_ext;
  logic [1:0]                      best_q, best_d;
  logic                            dec_valid_q, norm_q, norm_en;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  // Branch metric into each state from its even (bm0) and odd (bm1) predecessor.
  assign bm0 = {bm_s2_s3_i, bm_s0_s2_i, bm_s2_s1_i, bm_s0_s0_i};
  assign bm1 = {bm_s3_s3_i, bm_s1_s2_i, bm_s3_s1_i, bm_s1_s0_i};

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    acs_node #(.PM_W(PM_W)) u_node (
      .pm0_i (pm_q[P0_TAB[s]]),
      .pm1_i (pm_q[P1_TAB[s]]),
      .bm0_i (bm0[s]),
      .bm1_i (bm1[s]),
      .pm_o  (acs_pm[s]),
      .dec_o (acs_dec[s])
    );
  end

  always_comb begin
    norm_en = 1'b1;
    norm_pm = '0;
    pm_d    = '0;
    pm_ext  = '0;
    for (int s = 0; s < NUM_STATES; s++) norm_en = norm_en & acs_pm[s][PM_W-1];
    for (int s = 0; s < NUM_STATES; s++) begin
      norm_pm[s] = acs_pm[s] - (norm_en ? HALF : '0);
      pm_d[s]    = norm_pm[s][PM_W] ? {PM_W{1'b1}} : norm_pm[s][PM_W-1:0];
      pm_ext[s]  = pm_t'(pm_d[s]);
    end
    best_d = pm_argmin(pm_ext);
    cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // init_i reloads exactly like reset and swallows any symbol offered alongside it.
  always_ff @(posedge clk_i) begin
    if (rst_i || init_i) begin
      pm_q        <= {PEN, PEN, PEN, {PM_W{1'b0}}};
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      best_q      <= '0;
      norm_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      dec_valid_q <= bm_valid_i;
      norm_q      <= bm_valid_i & norm_en;
      if (bm_valid_i) begin
        pm_q   <= pm_d;
        dec_q  <= acs_dec;
        best_q <= best_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign dec_valid_o  = dec_valid_q;
  assign dec_o        = dec_q;
  assign pm_s0_o      = pm_q[0];
  assign pm_s1_o      = pm_q[1];
  assign pm_s2_o      = pm_q[2];
  assign pm_s3_o      = pm_q[3];
  assign best_state_o = best_q;
  assign norm_o       = norm_q;
  assign sym_cnt_o    = cnt_q;

endmodule

// File: tb/tb_acs_unit.sv
// Scoreboard bench for acs_unit: directed trellis vectors plus a noisy (7,5) encoder stream
// scored against an independent next-state-oriented Viterbi model.
module tb_acs_unit;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1, init_i = 1'b0, bm_valid_i = 1'b0;
  logic [1:0] bm_s0_s0, bm_s0_s2, bm_s1_s0, bm_s1_s2, bm_s2_s1, bm_s2_s3, bm_s3_s1, bm_s3_s3;
  logic       dec_valid_o, norm_o;
  logic [3:0] dec_o;
  logic [5:0] pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o;
  logic [1:0] best_state_o;
  logic [9:0] sym_cnt_o;

  acs_unit dut (
    .clk_i(clk), .rst_i(rst_i), .init_i(init_i), .bm_valid_i(bm_valid_i),
    .bm_s0_s0_i(bm_s0_s0), .bm_s0_s2_i(bm_s0_s2), .bm_s1_s0_i(bm_s1_s0), .bm_s1_s2_i(bm_s1_s2),
    .bm_s2_s1_i(bm_s2_s1), .bm_s2_s3_i(bm_s2_s3), .bm_s3_s1_i(bm_s3_s1), .bm_s3_s3_i(bm_s3_s3),
    .dec_valid_o(dec_valid_o), .dec_o(dec_o),
    .pm_s0_o(pm_s0_o), .pm_s1_o(pm_s1_o), .pm_s2_o(pm_s2_o), .pm_s3_o(pm_s3_o),
    .best_state_o(best_state_o), .norm_o(norm_o), .sym_cnt_o(sym_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][5:0] pm;
    logic [3:0]      dec;
    logic [1:0]      best;
    logic            norm;
    logic [9:0]      cnt;
  } exp_t;

  exp_t vq[$];   // expected outputs of accepted symbols
  exp_t sq[$];   // expected outputs on selected non-valid cycles
  int   compared = 0, mismatched = 0;
  bit   done = 1'b0, sat_seen = 1'b0;

  function automatic exp_t mk(input int p0, input int p1, input int p2, input int p3,
                              input logic [3:0] d, input int b, input logic n, input int c);
    exp_t e;
    e.pm   = {6'(p3), 6'(p2), 6'(p1), 6'(p0)};
    e.dec  = d;
    e.best = 2'(b);
    e.norm = n;
    e.cnt  = 10'(c);
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string n, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".pm0"}, pm_s0_o, e.pm[0]);
    chk({tag, ".pm1"}, pm_s1_o, e.pm[1]);
    chk({tag, ".pm2"}, pm_s2_o, e.pm[2]);
    chk({tag, ".pm3"}, pm_s3_o, e.pm[3]);
    chk({tag, ".dec"}, dec_o, e.dec);
    chk({tag, ".best"}, best_state_o, e.best);
    chk({tag, ".norm"}, norm_o, e.norm);
    chk({tag, ".cnt"}, sym_cnt_o, e.cnt);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dec_valid_o === 1'b1) begin
      if (vq.size() == 0) chk("unexpected_dec_valid", 1, 0);
      else begin
        e = vq.pop_front();
        cmp("sym", e);
      end
    end else if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("idle.dec_valid", dec_valid_o, 0);
      cmp("idle", e);
    end
    if (done) begin
      chk("pending_symbols", vq.size(), 0);
      chk("pending_idle_checks", sq.size(), 0);
      chk("model_saturation", sat_seen, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bm(input logic [15:0] b);
    {bm_s0_s0, bm_s0_s2, bm_s1_s0, bm_s1_s2, bm_s2_s1, bm_s2_s3, bm_s3_s1, bm_s3_s3} = b;
  endtask

  task automatic sym(input logic [15:0] b, input exp_t e);
    set_bm(b);
    bm_valid_i = 1'b1;
    vq.push_back(e);
    tick();
    bm_valid_i = 1'b0;
  endtask

  task automatic idle_check(input exp_t e);
    sq.push_back(e);
  endtask

  task automatic do_init();
    init_i = 1'b1;
    tick();
    init_i = 1'b0;
  endtask

  // Encoder / branch-metric reference: state = {newest bit, older bit}, generators 7 and 5.
  function automatic logic [1:0] code(input logic [1:0] s, input logic u);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  function automatic int ham(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return int'(x[0]) + int'(x[1]);
  endfunction

  localparam logic [15:0] RX00 = {2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
  localparam logic [15:0] RX11 = {2'd2, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
  localparam logic [15:0] ALL0 = 16'h0000;
  localparam logic [15:0] ALL1 = 16'h5555;
  localparam logic [15:0] ALL2 = 16'hAAAA;

  initial begin
    exp_t e, rst_e;
    int mpm[4], npm[4], mcnt, best;
    logic [3:0] mdec;
    logic [1:0] enc, r, c;
    logic u, nrm;

    rst_e = mk(0, 16, 16, 16, 4'b0000, 0, 1'b0, 0);
    set_bm(ALL0);
    tick(); tick();
    idle_check(rst_e);
    tick();
    rst_i = 1'b0;

    // Received 00 / 11 from a fresh frame, then a hold cycle.
    do_init();
    sym(RX00, mk(0, 17, 2, 17, 4'b0000, 0, 1'b0, 1));
    tick();
    idle_check(mk(0, 17, 2, 17, 4'b0000, 0, 1'b0, 1));
    do_init();
    sym(RX11, mk(2, 17, 0, 17, 4'b0000, 2, 1'b0, 1));

    // Uniform metrics: PMs merge after two symbols, all reach 32 on the 16th -> normalize to 0.
    do_init();
    sym(ALL2, mk(2, 18, 2, 18, 4'b0000, 0, 1'b0, 1));
    for (int k = 2; k <= 15; k++) sym(ALL2, mk(2*k, 2*k, 2*k, 2*k, 4'b0000, 0, 1'b0, k));
    sym(ALL2, mk(0, 0, 0, 0, 4'b0000, 0, 1'b1, 16));
    tick();
    idle_check(mk(0, 0, 0, 0, 4'b0000, 0, 1'b0, 16));

    // Decision bits: strictly better odd predecessor -> 1, equal candidates -> 0.
    do_init();
    sym(ALL0, mk(0, 16, 0, 16, 4'b0000, 0, 1'b0, 1));
    sym(ALL0, mk(0, 0, 0, 0, 4'b0000, 0, 1'b0, 2));
    sym({2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0}, mk(0, 0, 1, 0, 4'b1001, 0, 1'b0, 3));
    sym(ALL1, mk(1, 1, 1, 1, 4'b1010, 0, 1'b0, 4));

    // init together with a symbol: symbol dropped, frame reloaded.
    set_bm(ALL0);
    init_i = 1'b1;
    bm_valid_i = 1'b1;
    tick();
    init_i = 1'b0;
    bm_valid_i = 1'b0;
    idle_check(rst_e);

    // Reset in the middle of a stream, with a symbol offered.
    sym(RX00, mk(0, 17, 2, 17, 4'b0000, 0, 1'b0, 1));
    rst_i = 1'b1;
    bm_valid_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bm_valid_i = 1'b0;
    idle_check(rst_e);

    // Gapped valid pattern 1,0,0,1.
    do_init();
    sym(RX00, mk(0, 17, 2, 17, 4'b0000, 0, 1'b0, 1));
    tick();
    idle_check(mk(0, 17, 2, 17, 4'b0000, 0, 1'b0, 1));
    tick();
    idle_check(mk(0, 17, 2, 17, 4'b0000, 0, 1'b0, 1));
    sym(RX00, mk(0, 3, 2, 3, 4'b0000, 0, 1'b0, 2));

    // Noisy encoder stream, long enough to saturate the symbol counter.
    do_init();
    mpm = '{0, 16, 16, 16};
    mcnt = 0;
    enc = 2'b00;
    for (int i = 0; i < 1100; i++) begin
      u = 1'($urandom_range(0, 1));
      c = code(enc, u);
      enc = {u, enc[1]};
      r = c ^ {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      for (int ns = 0; ns < 4; ns++) begin
        logic [1:0] nsb, pa, pb;
        int ca, cb;
        nsb = 2'(ns);
        pa = {nsb[0], 1'b0};
        pb = {nsb[0], 1'b1};
        ca = mpm[pa] + ham(r, code(pa, nsb[1]));
        cb = mpm[pb] + ham(r, code(pb, nsb[1]));
        mdec[ns] = (cb < ca);
        npm[ns] = (cb < ca) ? cb : ca;
      end
      nrm = ((npm[0] & 32) != 0) && ((npm[1] & 32) != 0) && ((npm[2] & 32) != 0) && ((npm[3] & 32) != 0);
      best = 0;
      for (int s = 0; s < 4; s++) begin
        if (nrm) npm[s] = npm[s] - 32;
        if (npm[s] > 63) begin
          sat_seen = 1'b1;
          npm[s] = 63;
        end
        mpm[s] = npm[s];
      end
      for (int s = 1; s < 4; s++) if (mpm[s] < mpm[best]) best = s;
      if (mcnt < 1023) mcnt++;
      e = mk(mpm[0], mpm[1], mpm[2], mpm[3], mdec, best, nrm, mcnt);
      sym({2'(ham(r, code(2'd0, 1'b0))), 2'(ham(r, code(2'd0, 1'b1))),
           2'(ham(r, code(2'd1, 1'b0))), 2'(ham(r, code(2'd1, 1'b1))),
           2'(ham(r, code(2'd2, 1'b0))), 2'(ham(r, code(2'd2, 1'b1))),
           2'(ham(r, code(2'd3, 1'b0))), 2'(ham(r, code(2'd3, 1'b1)))}, e);
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick(); tick(); tick();
    done = 1'b1;
  end

endmodule
